// File: rtl/axi_i2c_pkg.sv
// Shared widths, AXI response codes and controller states for the AXI-to-I2C bridge.
package axi_i2c_pkg;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int RDATA_W = 32;
    localparam int RESP_W  = 2;
    localparam int OADDR_W = ADDR_W + DATA_W;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_WAIT,
        RD_RESP
    } state_e;

endpackage

// File: rtl/axi_hold_reg.sv
// Single-entry VALID/READY holding register: takes one beat, keeps it until cleared.
module axi_hold_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             clear_i,
    output logic             ready_o,
    output logic             full_o,
    output logic [WIDTH-1:0] data_o
);

    logic             full_q;
    logic [WIDTH-1:0] data_q;

    // Gated by reset so the bus never sees READY while the bridge is held in reset.
    assign ready_o = en_i & ~full_q & ~rst_i;
    assign full_o  = full_q;
    assign data_o  = data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (clear_i) begin
            full_q <= 1'b0;
        end else if (valid_i && ready_o) begin
            full_q <= 1'b1;
            data_q <= data_i;
        end
    end

endmodule

// File: rtl/axi_lite_slave.sv
// AXI4-Lite front end of the AXI-to-I2C bridge: forwards one write or read at a time
// to the I2C master and returns the AXI response once the master reports completion.
module axi_lite_slave
    import axi_i2c_pkg::*;
#(
    parameter int ADDR_WIDTH        = ADDR_W,
    parameter int DATA_WIDTH        = DATA_W,
    parameter int RDATA_WIDTH       = RDATA_W,
    parameter int RESPONSE_WIDTH    = RESP_W,
    parameter int OUTPUT_ADDR_WIDTH = ADDR_WIDTH + DATA_WIDTH
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic                         AWVALID,
    output logic                         AWREADY,
    input  logic [ADDR_WIDTH-1:0]        AWADDR,
    input  logic                         WVALID,
    output logic                         WREADY,
    input  logic [DATA_WIDTH-1:0]        WDATA,
    output logic                         BVALID,
    input  logic                         BREADY,
    output logic [RESPONSE_WIDTH-1:0]    BRESP,
    input  logic                         ARVALID,
    output logic                         ARREADY,
    input  logic [ADDR_WIDTH-1:0]        ARADDR,
    output logic                         RVALID,
    input  logic                         RREADY,
    output logic [RDATA_WIDTH-1:0]       RDATA,
    output logic [RESPONSE_WIDTH-1:0]    RRESP,
    output logic [OUTPUT_ADDR_WIDTH-1:0] ADDR_DATA_OUT,
    output logic                         VALID_ADDR_DATA_OUT,
    input  logic                         VALID_ADDR_DATA_OUT_ACK_VALID,
    input  logic                         VALID_ADDR_DATA_OUT_ACK,
    input  logic                         PENDING_TRANSACTION_WR,
    input  logic                         PENDING_TRANSACTION_RD,
    output logic                         I2C_MASTER_TRIGGER,
    input  logic                         RDATA_VALID,
    input  logic [RDATA_WIDTH-1:0]       RDATA_OUT,
    output logic                         RDATA_VALID_ACK
);

    state_e state_q, state_d;

    logic                      awFull, wFull, arFull;
    logic [ADDR_WIDTH-1:0]     awAddr, arAddr;
    logic [DATA_WIDTH-1:0]     wData;
    logic                      wrDone, rdDone;

    logic [RESPONSE_WIDTH-1:0] bresp_q, rresp_q;
    logic [RDATA_WIDTH-1:0]    rdata_q;
    logic                      rdataAck_q;

    assign wrDone = (state_q == WR_REQ)  && VALID_ADDR_DATA_OUT_ACK_VALID;
    assign rdDone = (state_q == RD_WAIT) && RDATA_VALID;

    axi_hold_reg #(.WIDTH(ADDR_WIDTH)) u_awReg (
        .clk_i   (ACLK),
        .rst_i   (ARESET),
        .en_i    (1'b1),
        .valid_i (AWVALID),
        .data_i  (AWADDR),
        .clear_i (wrDone),
        .ready_o (AWREADY),
        .full_o  (awFull),
        .data_o  (awAddr)
    );

    axi_hold_reg #(.WIDTH(DATA_WIDTH)) u_wReg (
        .clk_i   (ACLK),
        .rst_i   (ARESET),
        .en_i    (1'b1),
        .valid_i (WVALID),
        .data_i  (WDATA),
        .clear_i (wrDone),
        .ready_o (WREADY),
        .full_o  (wFull),
        .data_o  (wData)
    );

    // Reads are only accepted while idle so a queued write keeps priority.
    axi_hold_reg #(.WIDTH(ADDR_WIDTH)) u_arReg (
        .clk_i   (ACLK),
        .rst_i   (ARESET),
        .en_i    (state_q == IDLE),
        .valid_i (ARVALID),
        .data_i  (ARADDR),
        .clear_i (rdDone),
        .ready_o (ARREADY),
        .full_o  (arFull),
        .data_o  (arAddr)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (awFull && wFull && !PENDING_TRANSACTION_WR) begin
                    state_d = WR_REQ;
                end else if (arFull && !PENDING_TRANSACTION_RD) begin
                    state_d = RD_REQ;
                end
            end
            WR_REQ:  if (VALID_ADDR_DATA_OUT_ACK_VALID) state_d = WR_RESP;
            WR_RESP: if (BREADY)                        state_d = IDLE;
            RD_REQ:                                     state_d = RD_WAIT;
            RD_WAIT: if (RDATA_VALID)                   state_d = RD_RESP;
            RD_RESP: if (RREADY)                        state_d = IDLE;
            default:                                    state_d = IDLE;
        endcase
    end

    always_comb begin
        VALID_ADDR_DATA_OUT = (state_q == WR_REQ);
        I2C_MASTER_TRIGGER  = (state_q == RD_REQ);
        BVALID              = (state_q == WR_RESP);
        RVALID              = (state_q == RD_RESP);
        ADDR_DATA_OUT       = '0;
        case (state_q)
            WR_REQ:           ADDR_DATA_OUT = {awAddr, wData};
            RD_REQ, RD_WAIT:  ADDR_DATA_OUT = {arAddr, {DATA_WIDTH{1'b0}}};
            default:          ADDR_DATA_OUT = '0;
        endcase
    end

    // Response fields are registered so they stay stable while BVALID/RVALID wait.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            bresp_q    <= '0;
            rresp_q    <= '0;
            rdata_q    <= '0;
            rdataAck_q <= 1'b0;
        end else begin
            rdataAck_q <= rdDone;
            if (wrDone) begin
                bresp_q <= VALID_ADDR_DATA_OUT_ACK ? RESPONSE_WIDTH'(RESP_OKAY)
                                                   : RESPONSE_WIDTH'(RESP_SLVERR);
            end
            if (rdDone) begin
                rdata_q <= RDATA_OUT;
                rresp_q <= RESPONSE_WIDTH'(RESP_OKAY);
            end
        end
    end

    assign BRESP           = bresp_q;
    assign RRESP           = rresp_q;
    assign RDATA           = rdata_q;
    assign RDATA_VALID_ACK = rdataAck_q;

endmodule

// File: tb/tb_axi_lite_slave.sv
// Directed bench for axi_lite_slave with hand-computed expected values per cycle.
module tb_axi_lite_slave;

    logic        ACLK;
    logic        ARESET;
    logic        AWVALID, AWREADY;
    logic [31:0] AWADDR;
    logic        WVALID, WREADY;
    logic [31:0] WDATA;
    logic        BVALID, BREADY;
    logic [1:0]  BRESP;
    logic        ARVALID, ARREADY;
    logic [31:0] ARADDR;
    logic        RVALID, RREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic [63:0] ADDR_DATA_OUT;
    logic        VALID_ADDR_DATA_OUT;
    logic        ACK_VALID, ACK;
    logic        PEND_WR, PEND_RD;
    logic        TRIGGER;
    logic        RDATA_VALID;
    logic [31:0] RDATA_OUT;
    logic        RDATA_VALID_ACK;

    int checks   = 0;
    int failures = 0;

    axi_lite_slave dut (
        .ACLK                          (ACLK),
        .ARESET                        (ARESET),
        .AWVALID                       (AWVALID),
        .AWREADY                       (AWREADY),
        .AWADDR                        (AWADDR),
        .WVALID                        (WVALID),
        .WREADY                        (WREADY),
        .WDATA                         (WDATA),
        .BVALID                        (BVALID),
        .BREADY                        (BREADY),
        .BRESP                         (BRESP),
        .ARVALID                       (ARVALID),
        .ARREADY                       (ARREADY),
        .ARADDR                        (ARADDR),
        .RVALID                        (RVALID),
        .RREADY                        (RREADY),
        .RDATA                         (RDATA),
        .RRESP                         (RRESP),
        .ADDR_DATA_OUT                 (ADDR_DATA_OUT),
        .VALID_ADDR_DATA_OUT           (VALID_ADDR_DATA_OUT),
        .VALID_ADDR_DATA_OUT_ACK_VALID (ACK_VALID),
        .VALID_ADDR_DATA_OUT_ACK       (ACK),
        .PENDING_TRANSACTION_WR        (PEND_WR),
        .PENDING_TRANSACTION_RD        (PEND_RD),
        .I2C_MASTER_TRIGGER            (TRIGGER),
        .RDATA_VALID                   (RDATA_VALID),
        .RDATA_OUT                     (RDATA_OUT),
        .RDATA_VALID_ACK               (RDATA_VALID_ACK)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Advance one rising edge and let registered outputs settle.
    task automatic step();
        @(posedge ACLK);
        #2;
    endtask

    task automatic applyStimulus(input logic aw, input logic [31:0] awAddr,
                                 input logic w, input logic [31:0] wData);
        AWVALID = aw;
        AWADDR  = awAddr;
        WVALID  = w;
        WDATA   = wData;
    endtask

    initial begin
        ARESET = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        BREADY = 0; ARVALID = 0; ARADDR = 0; RREADY = 0;
        ACK_VALID = 0; ACK = 0; PEND_WR = 0; PEND_RD = 0;
        RDATA_VALID = 0; RDATA_OUT = 0;

        step();
        step();
        checkOutput("rst_awready", AWREADY, 1'b0);
        checkOutput("rst_arready", ARREADY, 1'b0);
        ARESET = 1'b0;
        #1;
        checkOutput("post_rst_awready", AWREADY, 1'b1);
        checkOutput("post_rst_wready", WREADY, 1'b1);
        checkOutput("post_rst_arready", ARREADY, 1'b1);
        checkOutput("rst_bvalid", BVALID, 1'b0);
        checkOutput("rst_rvalid", RVALID, 1'b0);
        checkOutput("rst_addr_data", ADDR_DATA_OUT, 64'h0);
        checkOutput("rst_trigger", TRIGGER, 1'b0);

        // Write OKAY: AW first, W three cycles later.
        applyStimulus(1'b1, 32'h1233_0002, 1'b0, 32'h0);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("w1_awready_full", AWREADY, 1'b0);
        step();
        step();
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h1);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("w1_wready_full", WREADY, 1'b0);
        checkOutput("w1_no_req_yet", VALID_ADDR_DATA_OUT, 1'b0);
        step();
        checkOutput("w1_req_valid", VALID_ADDR_DATA_OUT, 1'b1);
        checkOutput("w1_addr_data", ADDR_DATA_OUT, 64'h1233_0002_0000_0001);
        checkOutput("w1_bvalid_early", BVALID, 1'b0);
        ACK_VALID = 1; ACK = 1; BREADY = 1;
        step();
        checkOutput("w1_bvalid", BVALID, 1'b1);
        checkOutput("w1_bresp", BRESP, 2'b00);
        checkOutput("w1_req_dropped", VALID_ADDR_DATA_OUT, 1'b0);
        checkOutput("w1_awready_again", AWREADY, 1'b1);
        step();
        checkOutput("w1_bvalid_one_beat", BVALID, 1'b0);
        ACK_VALID = 0; ACK = 0; BREADY = 0;

        // Write NACK -> SLVERR, BREADY held low one cycle.
        applyStimulus(1'b1, 32'h1233_0002, 1'b1, 32'h1);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        step();
        checkOutput("w2_req_valid", VALID_ADDR_DATA_OUT, 1'b1);
        ACK_VALID = 1; ACK = 0;
        step();
        ACK_VALID = 0;
        checkOutput("w2_bvalid", BVALID, 1'b1);
        checkOutput("w2_bresp", BRESP, 2'b10);
        step();
        checkOutput("w2_bvalid_hold", BVALID, 1'b1);
        checkOutput("w2_bresp_hold", BRESP, 2'b10);
        BREADY = 1;
        step();
        checkOutput("w2_bvalid_done", BVALID, 1'b0);
        BREADY = 0;

        // W before AW, then a second AW that must wait.
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h5);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("w3_wready_full", WREADY, 1'b0);
        checkOutput("w3_awready_free", AWREADY, 1'b1);
        applyStimulus(1'b1, 32'h1234_AA1D, 1'b0, 32'h0);
        step();
        AWADDR = 32'hCAFE_0004;
        step();
        checkOutput("w3_addr_data", ADDR_DATA_OUT, 64'h1234_AA1D_0000_0005);
        checkOutput("w3_awready_stall", AWREADY, 1'b0);
        step();
        checkOutput("w3_awready_stall2", AWREADY, 1'b0);
        checkOutput("w3_req_hold", VALID_ADDR_DATA_OUT, 1'b1);
        ACK_VALID = 1; ACK = 1;
        step();
        ACK_VALID = 0;
        checkOutput("w3_bvalid", BVALID, 1'b1);
        checkOutput("w3_awready_release", AWREADY, 1'b1);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("w3_second_aw_taken", AWREADY, 1'b0);
        BREADY = 1;
        step();
        BREADY = 0;
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h7);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        step();
        checkOutput("w3_second_req", ADDR_DATA_OUT, 64'hCAFE_0004_0000_0007);
        ACK_VALID = 1; ACK = 1; BREADY = 1;
        step();
        ACK_VALID = 0;
        step();
        BREADY = 0;
        checkOutput("w3_idle", BVALID, 1'b0);

        // PENDING_TRANSACTION_WR holds the request back.
        PEND_WR = 1;
        applyStimulus(1'b1, 32'h0000_0010, 1'b1, 32'h55);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            step();
            checkOutput($sformatf("pend_blocked_%0d", i), VALID_ADDR_DATA_OUT, 1'b0);
        end
        PEND_WR = 0;
        step();
        checkOutput("pend_released", VALID_ADDR_DATA_OUT, 1'b1);
        checkOutput("pend_addr_data", ADDR_DATA_OUT, 64'h0000_0010_0000_0055);
        ACK_VALID = 1; ACK = 1; BREADY = 1;
        step();
        ACK_VALID = 0;
        step();
        BREADY = 0;

        // Read with RREADY held off for three cycles.
        ARVALID = 1; ARADDR = 32'h1233_0001;
        #1;
        checkOutput("r1_arready", ARREADY, 1'b1);
        step();
        ARVALID = 0;
        checkOutput("r1_arready_full", ARREADY, 1'b0);
        checkOutput("r1_no_trigger_yet", TRIGGER, 1'b0);
        step();
        checkOutput("r1_trigger", TRIGGER, 1'b1);
        checkOutput("r1_addr_data", ADDR_DATA_OUT, 64'h1233_0001_0000_0000);
        step();
        checkOutput("r1_trigger_pulse", TRIGGER, 1'b0);
        checkOutput("r1_rvalid_early", RVALID, 1'b0);
        RDATA_VALID = 1; RDATA_OUT = 32'hA5;
        step();
        RDATA_VALID = 0; RDATA_OUT = 32'h77;
        checkOutput("r1_rvalid", RVALID, 1'b1);
        checkOutput("r1_rdata", RDATA, 32'hA5);
        checkOutput("r1_rresp", RRESP, 2'b00);
        checkOutput("r1_rdata_ack", RDATA_VALID_ACK, 1'b1);
        step();
        checkOutput("r1_rdata_ack_pulse", RDATA_VALID_ACK, 1'b0);
        checkOutput("r1_rvalid_hold1", RVALID, 1'b1);
        step();
        checkOutput("r1_rvalid_hold2", RVALID, 1'b1);
        checkOutput("r1_rdata_hold", RDATA, 32'hA5);
        RREADY = 1;
        step();
        RREADY = 0;
        checkOutput("r1_rvalid_done", RVALID, 1'b0);
        checkOutput("r1_arready_again", ARREADY, 1'b1);

        // Write and read arriving together: write goes first.
        applyStimulus(1'b1, 32'h0000_0020, 1'b1, 32'h99);
        ARVALID = 1; ARADDR = 32'h0000_0030;
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        ARVALID = 0;
        step();
        checkOutput("tie_write_first", VALID_ADDR_DATA_OUT, 1'b1);
        checkOutput("tie_no_trigger", TRIGGER, 1'b0);
        ACK_VALID = 1; ACK = 1; BREADY = 1;
        step();
        ACK_VALID = 0;
        step();
        BREADY = 0;
        step();
        checkOutput("tie_read_trigger", TRIGGER, 1'b1);
        checkOutput("tie_read_addr", ADDR_DATA_OUT, 64'h0000_0030_0000_0000);
        step();
        RDATA_VALID = 1; RDATA_OUT = 32'h1234; RREADY = 1;
        step();
        RDATA_VALID = 0;
        checkOutput("tie_rdata", RDATA, 32'h1234);
        step();
        RREADY = 0;
        checkOutput("tie_rvalid_done", RVALID, 1'b0);

        // Reset in the middle of a write request.
        applyStimulus(1'b1, 32'hDEAD_0000, 1'b1, 32'hBEEF);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        step();
        checkOutput("rw_req_valid", VALID_ADDR_DATA_OUT, 1'b1);
        ARESET = 1;
        #1;
        checkOutput("rw_awready_in_reset", AWREADY, 1'b0);
        step();
        ARESET = 0;
        #1;
        checkOutput("rw_req_cleared", VALID_ADDR_DATA_OUT, 1'b0);
        checkOutput("rw_addr_data_cleared", ADDR_DATA_OUT, 64'h0);
        checkOutput("rw_bresp_cleared", BRESP, 2'b00);
        checkOutput("rw_awready", AWREADY, 1'b1);
        ACK_VALID = 1; ACK = 1; BREADY = 1;
        step();
        ACK_VALID = 0;
        checkOutput("rw_no_bvalid", BVALID, 1'b0);
        step();
        checkOutput("rw_no_bvalid2", BVALID, 1'b0);
        checkOutput("rw_no_new_req", VALID_ADDR_DATA_OUT, 1'b0);
        BREADY = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
